// File: rtl/cpu_ext_loader.sv
// Host-side session sequencer for the cpu external memory ports: streams a program into
// instruction memory, runs the core for a fixed cycle count, then dumps data memory words.
module cpu_ext_loader #(
   parameter int unsigned LEN_W = 16,
   parameter int unsigned RUN_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] prog_len,
   input  logic [RUN_W-1:0] run_cycles,
   input  logic [LEN_W-1:0] dump_len,
   input  logic             s_valid,
   input  logic [31:0]      s_data,
   output logic             s_ready,
   output logic             m_valid,
   output logic [31:0]      m_data,
   input  logic             m_ready,
   output logic             cpu_enable,
   output logic [31:0]      addr_ext,
   output logic             wen_ext,
   output logic [31:0]      wdata_ext,
   output logic [31:0]      addr_ext_2,
   output logic             ren_ext_2,
   output logic             wen_ext_2,
   output logic [31:0]      wdata_ext_2,
   input  logic [31:0]      rdata_ext_2,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_FLUSH = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_DREQ  = 3'd4;
   localparam logic [2:0] S_DWAIT = 3'd5;
   localparam logic [2:0] S_DOUT  = 3'd6;
   localparam logic [2:0] S_FIN   = 3'd7;

   localparam logic [LEN_W-1:0] IDX_ONE = LEN_W'(1);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [LEN_W-1:0] idx;
   logic [LEN_W-1:0] idx_nxt;
   logic [LEN_W-1:0] idx_inc;
   logic [RUN_W-1:0] run_cnt;
   logic [RUN_W-1:0] run_cnt_nxt;
   logic [LEN_W-1:0] prog_lat;
   logic [RUN_W-1:0] run_lat;
   logic [LEN_W-1:0] dump_lat;
   logic             accept;
   logic             hs_in;
   logic             hs_out;

   // Phase that follows the load phase, skipping any phase whose length is zero.
   function automatic logic [2:0] after_load(input logic [RUN_W-1:0] rc,
                                             input logic [LEN_W-1:0] dl);
      if (rc != '0)
         after_load = S_RUN;
      else if (dl != '0)
         after_load = S_DREQ;
      else
         after_load = S_FIN;
   endfunction

   function automatic logic [31:0] word_addr(input logic [LEN_W-1:0] i);
      word_addr = '0;
      word_addr[LEN_W+1:2] = i;
   endfunction

   assign accept  = (state == S_IDLE) && start;
   assign hs_in   = (state == S_LOAD) && s_valid && s_ready;
   assign hs_out  = (state == S_DOUT) && m_valid && m_ready;
   assign idx_inc = idx + IDX_ONE;

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      run_cnt_nxt = run_cnt;
      case (state)
         S_IDLE: begin
            if (start) begin
               idx_nxt     = '0;
               run_cnt_nxt = '0;
               state_nxt   = (prog_len != '0) ? S_LOAD : after_load(run_cycles, dump_len);
            end
         end
         S_LOAD: begin
            if (hs_in) begin
               idx_nxt = idx_inc;
               if (idx == prog_lat - IDX_ONE)
                  state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            idx_nxt   = '0;
            state_nxt = after_load(run_lat, dump_lat);
         end
         S_RUN: begin
            run_cnt_nxt = run_cnt + RUN_ONE;
            if (run_cnt == run_lat - RUN_ONE) begin
               idx_nxt   = '0;
               state_nxt = (dump_lat != '0) ? S_DREQ : S_FIN;
            end
         end
         S_DREQ:  state_nxt = S_DWAIT;
         S_DWAIT: state_nxt = S_DOUT;
         S_DOUT: begin
            if (hs_out) begin
               idx_nxt   = idx_inc;
               state_nxt = (idx_inc < dump_lat) ? S_DREQ : S_FIN;
            end
         end
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Every port-facing strobe is registered from the next state so each phase's
   // signal lines up with the cycle the FSM actually occupies that phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= '0;
         run_cnt    <= '0;
         prog_lat   <= '0;
         run_lat    <= '0;
         dump_lat   <= '0;
         s_ready    <= 1'b0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         cpu_enable <= 1'b0;
         addr_ext   <= '0;
         wen_ext    <= 1'b0;
         wdata_ext  <= '0;
         addr_ext_2 <= '0;
         ren_ext_2  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         run_cnt <= run_cnt_nxt;
         if (accept) begin
            prog_lat <= prog_len;
            run_lat  <= run_cycles;
            dump_lat <= dump_len;
         end
         s_ready <= (state_nxt == S_LOAD);
         wen_ext <= hs_in;
         if (hs_in) begin
            addr_ext  <= word_addr(idx);
            wdata_ext <= s_data;
         end
         cpu_enable <= (state_nxt == S_RUN);
         ren_ext_2  <= (state_nxt == S_DREQ);
         if (state_nxt == S_DREQ)
            addr_ext_2 <= word_addr(idx_nxt);
         if (state == S_DWAIT) begin
            m_valid <= 1'b1;
            m_data  <= rdata_ext_2;
         end else if (hs_out) begin
            m_valid <= 1'b0;
         end
         busy <= (state_nxt != S_IDLE);
         done <= (state_nxt == S_FIN);
      end
   end

   assign wen_ext_2   = 1'b0;
   assign wdata_ext_2 = '0;

endmodule

// File: tb/tb_cpu_ext_loader.sv
// Scoreboard bench for cpu_ext_loader: stimulus pushes expected port events into queues,
// a negedge monitor pops and checks them, and a small memory model answers data reads.
module tb_cpu_ext_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] prog_len;
   logic [31:0] run_cycles;
   logic [15:0] dump_len;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_ready;
   logic        cpu_enable;
   logic [31:0] addr_ext;
   logic        wen_ext;
   logic [31:0] wdata_ext;
   logic [31:0] addr_ext_2;
   logic        ren_ext_2;
   logic        wen_ext_2;
   logic [31:0] wdata_ext_2;
   logic [31:0] rdata_ext_2;
   logic        busy;
   logic        done;

   cpu_ext_loader #(.LEN_W(16), .RUN_W(32)) dut (
      .clk(clk), .rst(rst), .start(start),
      .prog_len(prog_len), .run_cycles(run_cycles), .dump_len(dump_len),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .cpu_enable(cpu_enable),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext),
      .addr_ext_2(addr_ext_2), .ren_ext_2(ren_ext_2),
      .wen_ext_2(wen_ext_2), .wdata_ext_2(wdata_ext_2),
      .rdata_ext_2(rdata_ext_2),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_wr[$];
   logic [31:0] exp_rd[$];
   logic [31:0] exp_dump[$];
   int          exp_run[$];

   logic [31:0] dmem [0:63];
   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int evt_cyc = 0;
   int ren_cyc = 0;
   int done_cnt = 0;
   int sessions = 0;
   int m_mode = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Data memory: read data appears the cycle after the read strobe, garbage otherwise.
   always @(posedge clk) begin
      if (ren_ext_2)
         rdata_ext_2 <= dmem[addr_ext_2[7:2]];
      else
         rdata_ext_2 <= $urandom;
   end

   initial begin
      int wcnt;
      wcnt = 0;
      m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (m_mode)
            0: m_ready = 1'b1;
            1: begin
               if (m_valid) begin
                  if (wcnt < 4) begin
                     m_ready = 1'b0;
                     wcnt++;
                  end else begin
                     m_ready = 1'b1;
                  end
               end else begin
                  wcnt = 0;
                  m_ready = 1'b0;
               end
            end
            default: m_ready = 1'($urandom_range(1, 0));
         endcase
      end
   end

   // Monitor: every phase must begin the cycle after the previous event of the session.
   int   run_len = 0;
   logic prev_mv = 1'b0;
   logic prev_mr = 1'b0;
   logic prev_done = 1'b0;
   logic [31:0] prev_md = '0;
   always @(negedge clk) begin
      int   anchor;
      wr_t  w;
      anchor = (start_cyc > evt_cyc) ? start_cyc : evt_cyc;
      if (wen_ext) begin
         if (exp_wr.size() == 0)
            check("wr_extra", wen_ext, 0);
         else begin
            w = exp_wr.pop_front();
            check("wr_addr", addr_ext, w.addr);
            check("wr_data", wdata_ext, w.data);
         end
         check("wen_vs_enable", cpu_enable, 0);
         evt_cyc = cyc;
      end
      if (ren_ext_2) begin
         if (exp_rd.size() == 0)
            check("rd_extra", ren_ext_2, 0);
         else
            check("rd_addr", addr_ext_2, exp_rd.pop_front());
         check("rd_latency", cyc, anchor + 1);
         check("ren_vs_enable", cpu_enable, 0);
         ren_cyc = cyc;
      end
      if (cpu_enable) begin
         if (run_len == 0)
            check("enable_latency", cyc, anchor + 1);
         run_len++;
         evt_cyc = cyc;
      end else if (run_len != 0) begin
         if (exp_run.size() == 0)
            check("run_extra", run_len, 0);
         else
            check("run_length", run_len, exp_run.pop_front());
         run_len = 0;
      end
      if (m_valid && !prev_mv)
         check("m_valid_latency", cyc, ren_cyc + 2);
      if (m_valid && prev_mv && !prev_mr)
         check("m_data_stable", m_data, prev_md);
      if (m_valid && m_ready) begin
         if (exp_dump.size() == 0)
            check("dump_extra", m_valid, 0);
         else
            check("dump_data", m_data, exp_dump.pop_front());
         evt_cyc = cyc;
      end
      if (done) begin
         check("done_latency", cyc, anchor + 1);
         done_cnt++;
      end
      if (prev_done)
         check("busy_after_done", busy, 0);
      prev_mv   = m_valid;
      prev_mr   = m_ready;
      prev_md   = m_data;
      prev_done = done;
   end

   task automatic do_start(input int p, input int r, input int d, input bit accepted);
      start      = 1'b1;
      prog_len   = 16'(p);
      run_cycles = 32'(r);
      dump_len   = 16'(d);
      if (accepted) begin
         start_cyc = cyc;
         sessions++;
         for (int i = 0; i < d; i++) begin
            exp_rd.push_back(32'(i * 4));
            exp_dump.push_back(dmem[i]);
         end
         if (r > 0)
            exp_run.push_back(r);
      end
      @(posedge clk);
      #1;
      start      = 1'b0;
      prog_len   = 16'($urandom);
      run_cycles = $urandom;
      dump_len   = 16'($urandom);
      if (accepted)
         check("busy_on_start", busy, 1);
   endtask

   // gmode: 0 continuous, 1 valid pattern 1,0,0,1,1, 2 random gaps.
   task automatic feed(input int n, input int total, input int gmode);
      int   gap;
      int   guard;
      logic hs;
      logic [31:0] wd;
      for (int i = 0; i < n; i++) begin
         gap = (gmode == 0) ? 0 : (gmode == 1) ? ((i == 1) ? 2 : 0) : int'($urandom_range(2, 0));
         s_valid = 1'b0;
         repeat (gap) begin
            s_data = $urandom;
            @(posedge clk);
            #1;
         end
         wd = $urandom;
         s_valid = 1'b1;
         s_data  = wd;
         exp_wr.push_back('{addr: 32'(i * 4), data: wd});
         guard = 0;
         do begin
            @(negedge clk);
            hs = s_ready;
            @(posedge clk);
            #1;
            guard++;
         end while (!hs && guard < 50);
         if (!hs)
            check("s_handshake_timeout", hs, 1);
      end
      s_valid = 1'b0;
      s_data  = $urandom;
      if (n > 0 && n == total)
         check("s_ready_drop", s_ready, 0);
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while (done_cnt < sessions && g < 2000) begin
         @(posedge clk);
         #1;
         g++;
      end
      check("session_done", done_cnt, sessions);
      @(posedge clk);
      #1;
      check("wr_queue_empty", exp_wr.size(), 0);
      check("rd_queue_empty", exp_rd.size(), 0);
      check("dump_queue_empty", exp_dump.size(), 0);
      check("run_queue_empty", exp_run.size(), 0);
   endtask

   task automatic session(input int p, input int r, input int d, input int gmode, input int mmode);
      m_mode = mmode;
      do_start(p, r, d, 1'b1);
      feed(p, p, gmode);
      wait_done();
   endtask

   initial begin
      for (int i = 0; i < 64; i++)
         dmem[i] = $urandom;
      rst = 1'b1; start = 1'b0; prog_len = '0; run_cycles = '0; dump_len = '0;
      s_valid = 1'b0; s_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_s_ready", s_ready, 0);
      check("reset_m_valid", m_valid, 0);
      check("reset_enable", cpu_enable, 0);
      check("reset_wen", wen_ext, 0);
      check("reset_ren", ren_ext_2, 0);
      check("reset_m_data", m_data, 0);
      repeat (2) @(posedge clk);
      #1;

      session(3, 5, 2, 0, 0);
      session(3, 2, 1, 1, 0);
      session(2, 1, 2, 0, 1);
      session(0, 0, 0, 0, 0);
      session(0, 4, 1, 0, 0);

      // Start while busy must leave the latched lengths alone.
      m_mode = 0;
      do_start(2, 6, 2, 1'b1);
      feed(2, 2, 0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("busy_mid_session", busy, 1);
      do_start(5, 1, 0, 1'b0);
      wait_done();

      // Reset during load after two of four words.
      do_start(4, 3, 1, 1'b1);
      feed(2, 4, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_s_ready", s_ready, 0);
      check("midrst_wen", wen_ext, 0);
      check("midrst_addr", addr_ext, 0);
      check("midrst_wdata", wdata_ext, 0);
      check("midrst_enable", cpu_enable, 0);
      check("midrst_done", done, 0);
      exp_wr.delete();
      exp_rd.delete();
      exp_dump.delete();
      exp_run.delete();
      sessions--;
      session(4, 2, 2, 0, 0);

      for (int k = 0; k < 6; k++)
         session(int'($urandom_range(5, 0)), int'($urandom_range(6, 0)),
                 int'($urandom_range(4, 0)), 2, 2);

      check("wen_ext_2_low", wen_ext_2, 0);
      check("wdata_ext_2_low", wdata_ext_2, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cpu_ext_loader.md
# cpu_ext_loader

Host-side initiator for the cpu external memory ports. On a start pulse it streams a program into instruction memory through `addr_ext`/`wen_ext`/`wdata_ext`, drives the cpu `enable` for a programmed number of cycles, then reads a programmed number of data memory words through `addr_ext_2`/`ren_ext_2` and returns them on an output stream. It sits beside `cpu` in the top-level test harness and owns every `*_ext` port of the core.

## Interface
- `LEN_W`, 16: width of the word counts and of the word index.
- `RUN_W`, 32: width of the run-cycle count.
- `clk` in 1: clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle session request; ignored unless idle.
- `prog_len` in LEN_W: number of instruction words to load; latched on accepted `start`.
- `run_cycles` in RUN_W: number of cycles `cpu_enable` is held; latched on accepted `start`.
- `dump_len` in LEN_W: number of data words to read back; latched on accepted `start`.
- `s_valid` in 1, `s_data` in 32, `s_ready` out 1: instruction word input stream.
- `m_valid` out 1, `m_data` out 32, `m_ready` in 1: data dump output stream.
- `cpu_enable` out 1: drives cpu `enable`.
- `addr_ext` out 32, `wen_ext` out 1, `wdata_ext` out 32: instruction memory write port.
- `addr_ext_2` out 32, `ren_ext_2` out 1: data memory read port; `wen_ext_2` out 1 and `wdata_ext_2` out 32 are held at 0.
- `rdata_ext_2` in 32: data memory read word.
- `busy` out 1, `done` out 1: status.

## Operation
- States: IDLE, LOAD, FLUSH, RUN, DREQ, DWAIT, DOUT, FIN.
- IDLE: `start` latches the three lengths, clears word index `idx` and run counter, and moves to LOAD if `prog_len`≠0, else RUN if `run_cycles`≠0, else DREQ if `dump_len`≠0, else FIN.
- LOAD: `s_ready`=1. Each handshake (`s_valid`&`s_ready`) registers `addr_ext`={idx,2'b00} zero-extended to 32, `wdata_ext`=`s_data`, `wen_ext`=1 for one cycle; `idx` increments. On the handshake of word `prog_len`-1 go to FLUSH; `s_ready` drops in the same edge.
- FLUSH: one cycle, the last write pulse is on the port. Then same skip rules as IDLE for RUN/DREQ/FIN.
- RUN: `cpu_enable`=1 for exactly `run_cycles` consecutive cycles, counter compared against the latched value; then DREQ or FIN; `idx` cleared on exit.
- DREQ: `addr_ext_2`={idx,2'b00}, `ren_ext_2`=1 for one cycle. Data memory read data is valid on `rdata_ext_2` in the following cycle.
- DWAIT: capture `rdata_ext_2` into `m_data`, set `m_valid`, go to DOUT.
- DOUT: hold `m_valid`/`m_data` until `m_ready`; on handshake clear `m_valid`, increment `idx`; go to DREQ if `idx`+1<`dump_len`, else FIN.
- FIN: `done`=1 for one cycle, return to IDLE.
- `busy`=1 in every state except IDLE; `start` while busy has no effect and does not modify the latched lengths.
- `wen_ext`, `ren_ext_2` are never high in the same cycle as `cpu_enable`.
- Index arithmetic is LEN_W bits; addresses are byte addresses of 32-bit words (index × 4).

## Timing
- Reset: state IDLE; every output 0 (`s_ready`, `m_valid`, `m_data`, `cpu_enable`, all `*_ext*` outputs, `busy`, `done`); counters 0.
- Reset mid-session: next edge returns to IDLE with all outputs 0; a pending write pulse or undelivered `m_data` is dropped.
- `start` sampled at edge t → `busy` high from t+1.
- Load: handshake at edge t → `wen_ext` high during cycle t+1 only; back-to-back handshakes give back-to-back write pulses.
- Last load handshake at t → FLUSH in t+1 → first `cpu_enable` cycle t+2.
- Last `cpu_enable` cycle c → `ren_ext_2` high in c+1 → `m_valid` high from c+3.
- Dump throughput: one word per 3 cycles with `m_ready` held high.
- `done` high for one cycle immediately after the final event; `busy` low the cycle after `done`.

## Test plan
- Full session: `prog_len`=3, `run_cycles`=5, `dump_len`=2, `s_valid` continuous with words A,B,C → writes to addresses 0x0,0x4,0x8 on consecutive cycles; `cpu_enable` high exactly 5 cycles; reads of 0x0,0x4 and data returned in order; one `done` pulse.
- Input gaps: `s_valid` toggled 1,0,0,1,1 → exactly one `wen_ext` pulse per handshake, addresses strictly incrementing, no pulses in gaps.
- Output backpressure: `m_ready` low 4 cycles per word → `m_data` stable while `m_valid` high, no extra `ren_ext_2` pulses, two words delivered.
- Zero lengths: all lengths 0 → FIN the cycle after start, `done` pulses, no write/enable/read activity; `prog_len`=0 only → `cpu_enable` starts the cycle after start.
- `start` while busy with different lengths → ignored; session completes with original lengths.
- `rst` asserted during LOAD after 2 of 4 words → all outputs 0 next cycle, `busy`=0; a new `start` restarts writes at address 0x0.
